// File: rtl/register_reader.sv
// ============================================================================
// Module   : register_reader
// Brief    : 4-entry register file with a ready/valid burst-read port.
//            Optional macro READ_BYPASS_EN forwards same-edge write data into
//            the read data register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_reader #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             writeEnable,
    input  logic [1:0]       writeAddr,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             readStart,
    input  logic [1:0]       readAddr,
    input  logic [1:0]       readLen,
    input  logic             readReady,
    output logic [WIDTH-1:0] dataOut,
    output logic             readValid,
    output logic             busy
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_mem [4];
    logic [WIDTH-1:0] r_data;
    logic [1:0]       r_ptr;
    logic [1:0]       r_cnt;

    logic             w_load;
    logic [1:0]       w_load_addr;
    logic [1:0]       w_ptr_next;
    logic [1:0]       w_cnt_next;
    logic [WIDTH-1:0] w_load_data;

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_addr  = r_ptr;
        w_ptr_next   = r_ptr;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (readStart) begin
                    w_state_next = S_BURST;
                    w_load       = 1'b1;
                    w_load_addr  = readAddr;
                    w_ptr_next   = readAddr + 2'd1;
                    w_cnt_next   = readLen;
                end
            end
            S_BURST: begin
                // A stalled consumer freezes data, pointer and count.
                if (readReady) begin
                    if (r_cnt != 2'd0) begin
                        w_load      = 1'b1;
                        w_load_addr = r_ptr;
                        w_ptr_next  = r_ptr + 2'd1;
                        w_cnt_next  = r_cnt - 2'd1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

`ifdef READ_BYPASS_EN
    assign w_load_data = (writeEnable && (writeAddr == w_load_addr)) ? dataIn
                                                                     : r_mem[w_load_addr];
`else
    assign w_load_data = r_mem[w_load_addr];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_ptr   <= 2'd0;
            r_cnt   <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (writeEnable) begin
                r_mem[writeAddr] <= dataIn;
            end
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_cnt   <= w_cnt_next;
            if (w_load) begin
                r_data <= w_load_data;
            end
        end
    end

    assign dataOut   = r_data;
    assign readValid = (r_state == S_BURST);
    assign busy      = (r_state == S_BURST);

endmodule

`default_nettype wire

// File: tb/tb_register_reader.sv
// ============================================================================
// Module   : tb_register_reader
// Brief    : Directed self-checking bench for register_reader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_reader;

    localparam int WIDTH = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             writeEnable;
    logic [1:0]       writeAddr;
    logic [WIDTH-1:0] dataIn;
    logic             readStart;
    logic [1:0]       readAddr;
    logic [1:0]       readLen;
    logic             readReady;
    logic [WIDTH-1:0] dataOut;
    logic             readValid;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    register_reader #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .writeEnable (writeEnable),
        .writeAddr   (writeAddr),
        .dataIn      (dataIn),
        .readStart   (readStart),
        .readAddr    (readAddr),
        .readLen     (readLen),
        .readReady   (readReady),
        .dataOut     (dataOut),
        .readValid   (readValid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [1:0] a, input logic [WIDTH-1:0] d);
        writeEnable = 1'b1;
        writeAddr   = a;
        dataIn      = d;
        tick();
        writeEnable = 1'b0;
    endtask

    // exp holds beat k in bits [2k+1:2k]
    task automatic run_burst(input string tag, input logic [1:0] addr,
                             input logic [1:0] len, input logic [7:0] exp);
        readStart = 1'b1;
        readAddr  = addr;
        readLen   = len;
        readReady = 1'b1;
        tick();
        readStart = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            check_eq($sformatf("%s valid%0d", tag, k), {31'd0, readValid}, 32'd1);
            check_eq($sformatf("%s beat%0d", tag, k), {30'd0, dataOut}, {30'd0, exp[k*2 +: 2]});
            tick();
        end
        check_eq({tag, " end valid/busy"}, {30'd0, readValid, busy}, 32'd0);
        check_eq({tag, " end hold"}, {30'd0, dataOut}, {30'd0, exp[int'(len)*2 +: 2]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b1;
        writeEnable = 1'b0;
        writeAddr   = 2'd0;
        dataIn      = '0;
        readStart   = 1'b0;
        readAddr    = 2'd0;
        readLen     = 2'd0;
        readReady   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_eq("reset outputs", {28'd0, readValid, busy, dataOut}, 32'd0);

        write_entry(2'd0, 2'd1);
        write_entry(2'd1, 2'd2);
        write_entry(2'd2, 2'd3);
        write_entry(2'd3, 2'd0);

        // Full 4-beat burst: 1,2,3,0
        run_burst("b4", 2'd0, 2'd3, {2'd0, 2'd3, 2'd2, 2'd1});
        // Wrap 3 -> 0: 0,1
        run_burst("wrap", 2'd3, 2'd1, {2'd0, 2'd0, 2'd1, 2'd0});

        // Stalled burst from entry 1: 2 (held 3 cycles), 3, 0
        readStart = 1'b1; readAddr = 2'd1; readLen = 2'd2; readReady = 1'b0;
        tick();
        readStart = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("stall hold%0d", k), {29'd0, readValid, dataOut}, 32'h6);
            if (k < 3) tick();
        end
        readReady = 1'b1;
        tick();
        check_eq("stall beat1", {29'd0, readValid, dataOut}, 32'h7);
        tick();
        check_eq("stall beat2", {29'd0, readValid, dataOut}, 32'h4);
        tick();
        check_eq("stall end", {30'd0, readValid, busy}, 32'd0);

        // Same-edge write and load of entry 2 (was 3)
        writeEnable = 1'b1; writeAddr = 2'd2; dataIn = 2'd1;
        readStart = 1'b1; readAddr = 2'd2; readLen = 2'd0; readReady = 1'b1;
        tick();
        writeEnable = 1'b0; readStart = 1'b0;
`ifdef READ_BYPASS_EN
        check_eq("bypass load", {30'd0, dataOut}, 32'd1);
`else
        check_eq("no-bypass load", {30'd0, dataOut}, 32'd3);
`endif
        tick();
        check_eq("bypass end", {30'd0, readValid, busy}, 32'd0);
        run_burst("after write", 2'd2, 2'd0, 8'h01);

        // Write to the entry being presented must not disturb dataOut
        readStart = 1'b1; readAddr = 2'd0; readLen = 2'd0; readReady = 1'b0;
        tick();
        readStart = 1'b0;
        write_entry(2'd0, 2'd2);
        check_eq("present stable", {29'd0, readValid, dataOut}, 32'h5);
        readReady = 1'b1;
        tick();
        check_eq("present end", {30'd0, readValid, busy}, 32'd0);
        // Entries now 2,2,1,0

        // readStart during burst and on final beat ignored; restart next cycle accepted
        readStart = 1'b1; readAddr = 2'd0; readLen = 2'd1; readReady = 1'b1;
        tick();
        readAddr = 2'd2; readLen = 2'd0;
        check_eq("ign beat0", {29'd0, readValid, dataOut}, 32'h6);
        tick();
        check_eq("ign beat1", {29'd0, readValid, dataOut}, 32'h6);
        tick();
        check_eq("ign idle", {30'd0, readValid, busy}, 32'd0);
        tick();
        readStart = 1'b0;
        check_eq("restart beat", {29'd0, readValid, dataOut}, 32'h5);
        tick();
        check_eq("restart end", {30'd0, readValid, busy}, 32'd0);

        // Reset mid-burst, with competing write and readStart
        readStart = 1'b1; readAddr = 2'd1; readLen = 2'd3; readReady = 1'b1;
        tick();
        readStart = 1'b0;
        check_eq("abort beat0", {29'd0, readValid, dataOut}, 32'h6);
        tick();
        check_eq("abort beat1", {29'd0, readValid, dataOut}, 32'h5);
        tick();
        reset = 1'b1; writeEnable = 1'b1; writeAddr = 2'd1; dataIn = 2'd3; readStart = 1'b1;
        tick();
        reset = 1'b0; writeEnable = 1'b0; readStart = 1'b0;
        check_eq("abort state", {28'd0, readValid, busy, dataOut}, 32'd0);
        tick();
        check_eq("abort no beats", {30'd0, readValid, busy}, 32'd0);
        run_burst("cleared", 2'd0, 2'd3, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/register_reader.md
REGISTER_READER -- requirements
Module: register_reader

Interface
REQ-001 Parameter: WIDTH, default 2, data bits per entry; depth is fixed at 4 entries.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 writeEnable  input  1  write strobe for the storage array.
REQ-005 writeAddr  input  2  entry index written when writeEnable=1.
REQ-006 dataIn  input  WIDTH  write data.
REQ-007 readStart  input  1  burst-read request, sampled only in IDLE.
REQ-008 readAddr  input  2  first entry index of the burst.
REQ-009 readLen  input  2  burst length minus one (0 -> 1 word, 3 -> 4 words).
REQ-010 readReady  input  1  consumer accepts the current beat.
REQ-011 dataOut  output  WIDTH  registered read data, stable while readValid=1 and readReady=0.
REQ-012 readValid  output  1  dataOut holds a valid beat.
REQ-013 busy  output  1  high in state BURST.

Function
REQ-014 The storage array SHALL be 4 x WIDTH; on a rising edge with writeEnable=1, entry writeAddr SHALL take dataIn, in any state.
REQ-015 The FSM SHALL have two states: IDLE (busy=0, readValid=0) and BURST (busy=1, readValid=1).
REQ-016 In IDLE with readStart=1 at edge N: state SHALL go to BURST, dataOut SHALL load entry readAddr, pointer SHALL set to readAddr+1, and remaining count SHALL set to readLen; readValid SHALL be 1 from cycle N+1.
REQ-017 A beat SHALL transfer on an edge where readValid=1 and readReady=1.
REQ-018 On a transfer with remaining count > 0: dataOut SHALL load entry at pointer, pointer SHALL increment modulo 4 (3 wraps to 0), and count SHALL decrement by 1.
REQ-019 On a transfer with remaining count = 0: state SHALL return to IDLE, readValid SHALL drop on the next cycle, and dataOut SHALL hold its last value.
REQ-020 While readValid=1 and readReady=0, dataOut, pointer and count SHALL not change.
REQ-021 readStart SHALL be ignored in BURST; a readStart in the same cycle as the final transfer SHALL be ignored, and the earliest accepted restart is the cycle after busy falls.
REQ-022 Exactly readLen+1 beats SHALL be delivered per burst; back-to-back transfers SHALL sustain one beat per cycle.
REQ-023 A write to an entry already loaded into dataOut SHALL not alter the dataOut value being presented.

Reset
REQ-024 reset=1 at an edge SHALL force state IDLE, readValid=0, busy=0, dataOut=0, pointer=0, count=0, and all 4 entries to 0.
REQ-025 reset SHALL take priority over writeEnable and readStart in the same cycle.
REQ-026 Reset during BURST SHALL abort the burst with no further beats.

Configuration
REQ-027 Macro READ_BYPASS_EN defined: when dataOut loads entry A on the same edge that writeEnable=1 and writeAddr=A, dataOut SHALL take dataIn (write-to-read forwarding).
REQ-028 Macro READ_BYPASS_EN undefined: in that case dataOut SHALL take the pre-write entry value; the new value is visible to loads from the next edge onward.

Verification
REQ-029 Reset, write entries 0..3 = 1,2,3,0; readStart with readAddr=0, readLen=3, readReady=1 -> readValid high 4 consecutive cycles, dataOut 1,2,3,0, then busy=0.
REQ-030 readAddr=3, readLen=1, readReady=1 -> dataOut 0 then 1 (wrap 3->0), 2 beats only.
REQ-031 readAddr=1, readLen=2, readReady held 0 for 3 cycles after the first beat -> dataOut stays 2 while stalled, then 3,0; exactly 3 beats delivered.
REQ-032 In IDLE: writeEnable=1, writeAddr=2, dataIn=1 with readStart=1, readAddr=2 in the same cycle (entry 2 was 3) -> first dataOut=1 with READ_BYPASS_EN defined, 3 without.
REQ-033 reset asserted mid-burst after 2 of 4 beats -> next cycle readValid=0, busy=0, dataOut=0, all entries read back 0.
REQ-034 readStart pulsed during BURST and on the final-beat cycle -> ignored, no extra beats; a readStart one cycle after busy falls is accepted.
